// File: rtl/avalon_word_seq_master.sv
// Avalon-MM word master: runs of single-word writes fed from an input stream, or single-word
// reads delivered on an output stream through a 2-entry buffer. Read latency is fixed at 1.
module avalon_word_seq_master #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned LEN_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StFinish} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  xfer_q;     // words taken (write run) or reads issued (read run)
    logic [LEN_W-1:0]  dlv_q;      // words handed to the consumer
    logic              write_q;
    logic [31:0]       wdata_q;
    logic              rd_pend_q;  // read presented but stalled; must stay up
    logic              inflight_q; // read accepted last cycle, data on avm_readdata now
    logic [31:0]       fifo_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;

    logic              take, wr_acc, rd_req, rd_acc, pop;
    logic [2:0]        occ;

    // Handshake decode and bus/stream outputs
    always_comb begin
        in_ready = (state_q == StWrite) && (xfer_q < len_q) && (!write_q || !avm_waitrequest);
        take     = in_valid && in_ready;
        wr_acc   = write_q && !avm_waitrequest;
        out_valid = (count_q != 2'd0);
        out_data  = fifo_q[rd_ptr_q];
        pop       = out_valid && out_ready;
        // Buffer slots committed after this cycle; counting the same-cycle pop keeps reads
        // back-to-back when the consumer drains every cycle.
        occ    = 3'(count_q) + 3'(inflight_q) - 3'(pop);
        rd_req = (state_q == StRead) && (xfer_q < len_q) && (rd_pend_q || (occ < 3'd2));
        rd_acc = rd_req && !avm_waitrequest;

        avm_read       = rd_req;
        avm_write      = write_q;
        avm_chipselect = rd_req || write_q;
        avm_address    = addr_q;
        avm_writedata  = wdata_q;
        avm_byteenable = 4'hF;
        busy           = (state_q != StIdle);
        done           = (state_q == StFinish);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    if (cmd_len == '0) begin
                        state_d = StFinish;
                    end else begin
                        state_d = cmd_write ? StWrite : StRead;
                    end
                end
            end
            StWrite: begin
                // With every word taken, the pending write is the last one
                if (wr_acc && (xfer_q == len_q)) begin
                    state_d = StFinish;
                end
            end
            StRead: begin
                if (pop && (dlv_q == len_q - LEN_W'(1))) begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State, counters, bus registers and read buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= '0;
            xfer_q     <= '0;
            dlv_q      <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            rd_pend_q  <= 1'b0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd_acc;
            rd_pend_q  <= rd_req && avm_waitrequest;

            if ((state_q == StIdle) && cmd_start) begin
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
                xfer_q <= '0;
                dlv_q  <= '0;
            end

            if (take) begin
                wdata_q <= in_data;
                write_q <= 1'b1;
                xfer_q  <= xfer_q + LEN_W'(1);
            end else if (wr_acc) begin
                write_q <= 1'b0;
            end

            if (rd_acc) begin
                xfer_q <= xfer_q + LEN_W'(1);
            end

            if (wr_acc || rd_acc) begin
                addr_q <= addr_q + ADDR_W'(1);
            end

            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= avm_readdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end

            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                dlv_q    <= dlv_q + LEN_W'(1);
            end

            count_q <= count_q + 2'(inflight_q) - 2'(pop);
        end
    end

endmodule
